// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch unit bus bundle.
// Groups the SRAM-like instruction bus and the instruction FIFO write port.
//   ibus_req / ibus_addr          : fetch request and 8-byte aligned address
//   ibus_addr_ok / ibus_data_ok   : address accepted / read data valid
//   ibus_rdata                    : [31:0] word at addr, [63:32] word at addr+4
//   fifo_write_en1/2, data1/2,
//   fifo_write_address1/2         : up to two instruction writes per beat
// master = fetch unit side, slave = bus/FIFO side.
interface instruction_fetch_unit_if;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_addr_ok;
   logic        ibus_data_ok;
   logic [63:0] ibus_rdata;
   logic        fifo_write_en1;
   logic        fifo_write_en2;
   logic [31:0] fifo_write_data1;
   logic [31:0] fifo_write_data2;
   logic [31:0] fifo_write_address1;
   logic [31:0] fifo_write_address2;

   modport master (
      output ibus_req, ibus_addr,
      input  ibus_addr_ok, ibus_data_ok, ibus_rdata,
      output fifo_write_en1, fifo_write_en2, fifo_write_data1, fifo_write_data2,
             fifo_write_address1, fifo_write_address2
   );

   modport slave (
      input  ibus_req, ibus_addr,
      output ibus_addr_ok, ibus_data_ok, ibus_rdata,
      input  fifo_write_en1, fifo_write_en2, fifo_write_data1, fifo_write_data2,
             fifo_write_address1, fifo_write_address2
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: producer side of the dual-issue instruction FIFO.
// Holds the fetch PC, issues one 64-bit aligned fetch at a time and writes one
// or two instructions per returned beat into the FIFO. Backend redirects
// retarget the PC; a fetch in flight when a redirect arrives is dropped.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   redirect_valid    : one-cycle redirect strobe
//   redirect_pc       : redirect target (bits [1:0] ignored)
//   fifo_full         : FIFO occupancy >= 14
//   fetch_count       : instructions written to the FIFO (wraps)
//   discard_count     : beats dropped due to redirect (wraps)
//   bus               : instruction bus + FIFO write port (master side)
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            redirect_valid,
   input  logic [31:0]                     redirect_pc,
   input  logic                            fifo_full,
   output logic [31:0]                     fetch_count,
   output logic [31:0]                     discard_count,
   instruction_fetch_unit_if.master        bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] req_pc_q;
   logic [31:0] fetch_cnt_q;
   logic [31:0] disc_cnt_q;

   logic [31:0] redir_pc;
   logic        wr_beat;
   logic        wr_two;

   assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

   // A beat is written only if it is still current in the data_ok cycle;
   // a coincident redirect makes it stale.
   assign wr_beat = (state_q == S_WAIT) && bus.ibus_data_ok && !redirect_valid;
   // An odd-word start PC only yields the upper word of the beat.
   assign wr_two  = wr_beat && !req_pc_q[2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'd0;
         fetch_cnt_q <= 32'd0;
         disc_cnt_q  <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Mandatory idle cycle: fifo_full already reflects the last write.
               if (redirect_valid)  pc_q    <= redir_pc;
               else if (!fifo_full) state_q <= S_REQ;
            end
            S_REQ: begin
               if (bus.ibus_addr_ok) begin
                  if (redirect_valid) begin
                     pc_q    <= redir_pc;
                     state_q <= S_DISCARD;
                  end else begin
                     req_pc_q <= pc_q;
                     state_q  <= S_WAIT;
                  end
               end else if (redirect_valid) begin
                  // Not yet accepted: simply retarget the pending request.
                  pc_q <= redir_pc;
               end
            end
            S_WAIT: begin
               if (bus.ibus_data_ok) begin
                  if (redirect_valid) begin
                     pc_q       <= redir_pc;
                     disc_cnt_q <= disc_cnt_q + 32'd1;
                  end else begin
                     pc_q        <= {req_pc_q[31:3] + 29'd1, 3'b000};
                     fetch_cnt_q <= fetch_cnt_q + (wr_two ? 32'd2 : 32'd1);
                  end
                  state_q <= S_IDLE;
               end else if (redirect_valid) begin
                  pc_q    <= redir_pc;
                  state_q <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (redirect_valid) pc_q <= redir_pc;
               if (bus.ibus_data_ok) begin
                  disc_cnt_q <= disc_cnt_q + 32'd1;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ibus_req  = (state_q == S_REQ);
   assign bus.ibus_addr = {pc_q[31:3], 3'b000};

   always_comb begin
      bus.fifo_write_en1      = 1'b0;
      bus.fifo_write_en2      = 1'b0;
      bus.fifo_write_data1    = 32'd0;
      bus.fifo_write_data2    = 32'd0;
      bus.fifo_write_address1 = 32'd0;
      bus.fifo_write_address2 = 32'd0;
      if (wr_beat) begin
         bus.fifo_write_en1      = 1'b1;
         bus.fifo_write_address1 = req_pc_q;
         bus.fifo_write_data1    = req_pc_q[2] ? bus.ibus_rdata[63:32] : bus.ibus_rdata[31:0];
      end
      if (wr_two) begin
         bus.fifo_write_en2      = 1'b1;
         bus.fifo_write_data2    = bus.ibus_rdata[63:32];
         bus.fifo_write_address2 = req_pc_q + 32'd4;
      end
   end

   assign fetch_count   = fetch_cnt_q;
   assign discard_count = disc_cnt_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Producer side of the instruction FIFO in the dual-issue pipeline. It holds the fetch PC, issues one 64-bit aligned fetch at a time on the SRAM-like instruction bus, and writes one or two instructions per returned beat into the FIFO write port (`write_en1/2`, data, address). Backend redirects (branches, exceptions, delay-slot replays) retarget it. Any fetch already in flight when a redirect arrives is dropped.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: fetch PC after reset; bits [1:0] must be zero.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `redirect_valid` in 1: backend redirect strobe, one cycle.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `fifo_full` in 1: FIFO full flag (count ≥ 14).
- `ibus_req` out 1: fetch request.
- `ibus_addr` out 32: request address, always 8-byte aligned.
- `ibus_addr_ok` in 1: address accepted this cycle.
- `ibus_data_ok` in 1: read data valid this cycle.
- `ibus_rdata` in 64: [31:0] = word at addr, [63:32] = word at addr+4.
- `fifo_write_en1`, `fifo_write_en2` out 1: FIFO write strobes.
- `fifo_write_data1`, `fifo_write_data2` out 32: instructions.
- `fifo_write_address1`, `fifo_write_address2` out 32: instruction PCs.
- `fetch_count` out 32: instructions written to the FIFO, wraps mod 2^32.
- `discard_count` out 32: fetch beats dropped because of a redirect, wraps.

## Operation
- Registers: `pc[31:0]`, `req_pc[31:0]` (PC of the in-flight fetch), `state`, and both counters.
- States:
  - IDLE: no request.
    - `redirect_valid` → `pc <= redirect_pc`, stay IDLE.
    - Else if `!fifo_full` → REQ.
  - REQ: `ibus_req=1`, `ibus_addr={pc[31:3],3'b0}`.
    - `addr_ok` without redirect → `req_pc <= pc`, go to WAIT.
    - `addr_ok` with redirect → `pc <= redirect_pc`, go to DISCARD.
    - Redirect without `addr_ok` → `pc <= redirect_pc`, stay REQ; the new address is driven next cycle.
  - WAIT: `ibus_req=0`.
    - `data_ok` without redirect → FIFO write (below), `pc <= {req_pc[31:3]+1,3'b0}`, go to IDLE.
    - `data_ok` with redirect → no write, `pc <= redirect_pc`, `discard_count+1`, go to IDLE.
    - Redirect without `data_ok` → `pc <= redirect_pc`, go to DISCARD.
  - DISCARD: `ibus_req=0`.
    - `data_ok` → no write, `discard_count+1`, go to IDLE.
    - A redirect in the same cycle or earlier updates `pc`.
- FIFO write happens in the `data_ok` cycle and is combinational from state and inputs:
  - `req_pc[2]==0`: `en1=en2=1`; `data1=rdata[31:0]` with `addr1=req_pc`; `data2=rdata[63:32]` with `addr2=req_pc+4`; `fetch_count += 2`.
  - `req_pc[2]==1`: `en1=1`, `en2=0`; `data1=rdata[63:32]` with `addr1=req_pc`; `fetch_count += 1`.
- When an enable is low, its data and address outputs are 0.
- Only one fetch is ever outstanding. The mandatory IDLE cycle after each beat lets `fifo_full` reflect the latest write before the next issue. Issuing only while count ≤ 13 bounds the count at 15, so the FIFO never overflows.
- `en2` is never high without `en1`.

## Timing
- Reset values:
  - State IDLE, `pc=RESET_PC`, `req_pc=0`, both counters 0.
  - All outputs 0, except `ibus_addr = {RESET_PC[31:3],3'b0}`.
- First `ibus_req` is driven on the 2nd cycle after `rst` falls (IDLE → REQ), provided `!fifo_full`.
- Zero-wait bus throughput: REQ(addr_ok) → WAIT(data_ok) → IDLE → REQ. That is one beat per 3 cycles. Best case is 2 instructions per 3 cycles.
- `addr_ok` and `data_ok` in the same cycle is illegal for this bus. The unit does not need to handle it.
- Redirect-to-request latency:
  - From IDLE: 2 cycles.
  - From REQ before `addr_ok`: the new address is on the bus the next cycle.
- `rst` mid-fetch: back to IDLE and `RESET_PC`. The bus is reset with the core, so no response is pending after reset.
- If `fifo_full` is held high, the unit stays in IDLE indefinitely.

## Test plan
- **Reset and first fetch**:
  - Stimulus: `rst` for 2 cycles, then release; `addr_ok` on the first req; `data_ok` the next cycle with `rdata=64'h2400_0002_2400_0001`.
  - Required: `ibus_addr=BFC00000`; `en1=en2=1`; data1=24000001 at addr1=BFC00000; data2=24000002 at addr2=BFC00004; next `ibus_addr=BFC00008`; `fetch_count=2`.
- **Odd-word redirect**:
  - Stimulus: redirect to 8000_0014 while IDLE.
  - Required: `ibus_addr=80000010`; on data: `en1=1`, `en2=0`, data1 = rdata[63:32], addr1 = 80000014; next addr = 80000018; `fetch_count +1`.
- **Redirect while WAIT**:
  - Stimulus: redirect to 8000_0100 two cycles before `data_ok`.
  - Required: no FIFO write for the stale beat; `discard_count=1`; next `ibus_addr=80000100`.
- **Redirect coincident with data_ok**:
  - Required: no write; `pc` = redirect target; `discard_count +1`.
- **FIFO full backpressure**:
  - Stimulus: hold `fifo_full=1` for 10 cycles while IDLE.
  - Required: `ibus_req=0` throughout; request resumes 1 cycle after `fifo_full` drops; no write ever occurs while the count could exceed 15.
- **Reset mid-WAIT**:
  - Stimulus: assert `rst` in WAIT.
  - Required: all outputs 0, counters 0; the next request goes to BFC00000.
